// File: rtl/clcoding_sequencer.sv
// clcoding_sequencer: controller in front of the clcoding RLE datapath.
// Optionally zero-clears the LL and D code-length RAMs, scans both to find
// HLIT/HDIST by trimming trailing zero lengths, then streams the trimmed,
// concatenated code-length sequence over a valid/ready handshake.
// Optional build macro CLCODING_SEQUENCER_STATS_EN adds the zero_cnt output,
// which counts transferred zero-length elements of the current job.

module clcoding_sequencer #(
  parameter int LL_DEPTH = 286,
  parameter int D_DEPTH  = 30,
  parameter int CL_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            clear_first,
  output logic [8:0]      ll_addr,
  output logic            ll_we,
  output logic [CL_W-1:0] ll_wdata,
  input  logic [CL_W-1:0] ll_rdata,
  output logic [4:0]      d_addr,
  output logic            d_we,
  output logic [CL_W-1:0] d_wdata,
  input  logic [CL_W-1:0] d_rdata,
  output logic            cl_valid,
  input  logic            cl_ready,
  output logic [CL_W-1:0] cl_data,
  output logic            cl_last,
  output logic [4:0]      hlit,
  output logic [4:0]      hdist,
  output logic            busy,
  output logic            done
`ifdef CLCODING_SEQUENCER_STATS_EN
  ,
  output logic [8:0]      zero_cnt
`endif
);

  localparam logic [8:0] LL_DEPTH9 = 9'(LL_DEPTH);
  localparam logic [8:0] D_DEPTH9  = 9'(D_DEPTH);
  localparam logic [8:0] LL_LAST   = 9'(LL_DEPTH - 1);
  localparam logic [8:0] SCAN_END  = 9'(LL_DEPTH + D_DEPTH);
  localparam logic [8:0] MIN_LL    = 9'd257;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [8:0]      cnt;
  logic [8:0]      ll_cnt;
  logic [5:0]      d_cnt;
  logic [8:0]      n_ll;
  logic [5:0]      n_d;
  logic            issue_done;
  logic            rd_v;
  logic            rd_is_d;
  logic            rd_last;
  logic            sk_v;
  logic [CL_W-1:0] sk_data;
  logic            sk_last;

  logic [8:0]      cnt_inc;
  logic [8:0]      scan_ll_cnt_nxt;
  logic [5:0]      scan_d_cnt_nxt;
  logic [8:0]      n_ll_nxt;
  logic [5:0]      n_d_nxt;
  logic [8:0]      emit_last;
  logic [2:0]      fill;
  logic            pop;
  logic            advance;
  logic [CL_W-1:0] in_data;

  // The RAMs are only ever written with zeros.
  assign ll_wdata = '0;
  assign d_wdata  = '0;

  // Scan trackers hold (last nonzero index + 1) so that 0 means "none yet";
  // the emit side decides whether the next read may be committed so the
  // returning word always has a free slot in the output or skid register.
  always_comb begin
    cnt_inc         = cnt + 9'd1;
    scan_ll_cnt_nxt = ll_cnt;
    scan_d_cnt_nxt  = d_cnt;
    if (state == S_SCAN && cnt != 9'd0) begin
      if (cnt <= LL_DEPTH9) begin
        if (ll_rdata != '0) scan_ll_cnt_nxt = cnt;
      end else begin
        if (d_rdata != '0) scan_d_cnt_nxt = 6'(cnt - LL_DEPTH9);
      end
    end
    n_ll_nxt  = (scan_ll_cnt_nxt < MIN_LL) ? MIN_LL : scan_ll_cnt_nxt;
    n_d_nxt   = (scan_d_cnt_nxt == 6'd0) ? 6'd1 : scan_d_cnt_nxt;
    emit_last = n_ll + {3'b000, n_d} - 9'd1;
    pop       = cl_valid & cl_ready;
    fill      = {2'b00, cl_valid} + {2'b00, sk_v} + {2'b00, rd_v};
    advance   = (state == S_EMIT) && !issue_done && (fill <= ({2'b00, pop} + 3'd1));
    in_data   = rd_is_d ? d_rdata : ll_rdata;
  end

  // Main sequencer: clear, scan, emit and done phases with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ll_cnt     <= '0;
      d_cnt      <= '0;
      n_ll       <= MIN_LL;
      n_d        <= 6'd1;
      issue_done <= 1'b0;
      rd_v       <= 1'b0;
      rd_is_d    <= 1'b0;
      rd_last    <= 1'b0;
      sk_v       <= 1'b0;
      sk_data    <= '0;
      sk_last    <= 1'b0;
      ll_addr    <= '0;
      ll_we      <= 1'b0;
      d_addr     <= '0;
      d_we       <= 1'b0;
      cl_valid   <= 1'b0;
      cl_data    <= '0;
      cl_last    <= 1'b0;
      hlit       <= '0;
      hdist      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            ll_addr <= '0;
            d_addr  <= '0;
            ll_cnt  <= '0;
            d_cnt   <= '0;
            if (clear_first) begin
              state <= S_CLEAR;
              ll_we <= 1'b1;
              d_we  <= 1'b1;
            end else begin
              state <= S_SCAN;
            end
          end
        end

        S_CLEAR: begin
          if (cnt == LL_LAST) begin
            state   <= S_SCAN;
            ll_we   <= 1'b0;
            d_we    <= 1'b0;
            cnt     <= '0;
            ll_addr <= '0;
            d_addr  <= '0;
            ll_cnt  <= '0;
            d_cnt   <= '0;
          end else begin
            cnt     <= cnt_inc;
            ll_addr <= cnt_inc;
            if (cnt_inc < D_DEPTH9) begin
              d_we   <= 1'b1;
              d_addr <= 5'(cnt_inc);
            end else begin
              d_we <= 1'b0;
            end
          end
        end

        S_SCAN: begin
          ll_cnt <= scan_ll_cnt_nxt;
          d_cnt  <= scan_d_cnt_nxt;
          if (cnt == SCAN_END) begin
            state      <= S_EMIT;
            n_ll       <= n_ll_nxt;
            n_d        <= n_d_nxt;
            hlit       <= 5'(n_ll_nxt - MIN_LL);
            hdist      <= 5'(n_d_nxt - 6'd1);
            cnt        <= '0;
            ll_addr    <= '0;
            d_addr     <= '0;
            issue_done <= 1'b0;
            rd_v       <= 1'b0;
            sk_v       <= 1'b0;
            cl_valid   <= 1'b0;
            cl_last    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc < LL_DEPTH9) begin
              ll_addr <= cnt_inc;
            end else if (cnt_inc < SCAN_END) begin
              d_addr <= 5'(cnt_inc - LL_DEPTH9);
            end
          end
        end

        S_EMIT: begin
          if (advance) begin
            rd_v    <= 1'b1;
            rd_is_d <= (cnt >= n_ll);
            rd_last <= (cnt == emit_last);
            if (cnt == emit_last) begin
              issue_done <= 1'b1;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc < n_ll) begin
                ll_addr <= cnt_inc;
              end else begin
                d_addr <= 5'(cnt_inc - n_ll);
              end
            end
          end else begin
            rd_v <= 1'b0;
          end

          if (!cl_valid || pop) begin
            if (sk_v) begin
              cl_valid <= 1'b1;
              cl_data  <= sk_data;
              cl_last  <= sk_last;
              if (rd_v) begin
                sk_v    <= 1'b1;
                sk_data <= in_data;
                sk_last <= rd_last;
              end else begin
                sk_v <= 1'b0;
              end
            end else if (rd_v) begin
              cl_valid <= 1'b1;
              cl_data  <= in_data;
              cl_last  <= rd_last;
            end else begin
              cl_valid <= 1'b0;
              cl_last  <= 1'b0;
            end
          end else if (rd_v) begin
            sk_v    <= 1'b1;
            sk_data <= in_data;
            sk_last <= rd_last;
          end

          if (pop && cl_last) begin
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cl_valid <= 1'b0;
            cl_last  <= 1'b0;
            cl_data  <= '0;
            sk_v     <= 1'b0;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLCODING_SEQUENCER_STATS_EN
  // Counts zero-length elements actually handed to clcoding in this job.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      zero_cnt <= '0;
    end else if (pop && cl_data == '0) begin
      zero_cnt <= zero_cnt + 9'd1;
    end
  end
`else
  // This build carries no statistics counter.
`endif

endmodule

// File: doc/clcoding_sequencer.md
Name: clcoding_sequencer

Overview:
- Controller in front of the clcoding RLE datapath.
- Optionally zero-clears the literal/length (LL) and distance (D) code-length RAMs.
- Scans both RAMs to derive HLIT/HDIST by trimming trailing zero lengths, then streams the trimmed, concatenated code-length sequence to clcoding over a valid/ready handshake.
- Owns the RAM ports during its operation; upstream Huffman builders must not access the RAMs while busy=1.

Parameters:
- LL_DEPTH, 286, LL code-length RAM entries.
- D_DEPTH, 30, D code-length RAM entries.
- CL_W, 4, code-length word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- start  in  1  one-cycle job request; ignored while busy=1.
- clear_first  in  1  sampled with start; 1 = run the CLEAR phase before SCAN.
- ll_addr  out  9  LL RAM address (shared read/write).
- ll_we  out  1  LL RAM write enable.
- ll_wdata  out  CL_W  LL write data; always 0.
- ll_rdata  in  CL_W  LL read data; valid one cycle after ll_addr.
- d_addr  out  5  D RAM address.
- d_we  out  1  D RAM write enable.
- d_wdata  out  CL_W  always 0.
- d_rdata  in  CL_W  D read data; one-cycle latency.
- cl_valid  out  1  stream element valid.
- cl_ready  in  1  clcoding accepts the element.
- cl_data  out  CL_W  code length.
- cl_last  out  1  marks the final element of the job.
- hlit  out  5  number of LL codes minus 257; valid from SCAN end until the next start.
- hdist  out  5  number of D codes minus 1; same validity as hlit.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state=IDLE. All outputs 0: addresses, we, wdata, cl_*, hlit, hdist, busy, done. Counters and last-nonzero trackers cleared. Reset mid-job aborts immediately; no further RAM writes occur after the reset cycle.
- IDLE:
  - start=1 → CLEAR if clear_first=1, else SCAN; busy=1 next cycle.
  - start while busy=1 has no effect.
- CLEAR:
  - Counter k runs 0..LL_DEPTH-1.
  - ll_we=1, ll_addr=k every cycle.
  - d_we=1, d_addr=k only while k<D_DEPTH.
  - Lasts exactly LL_DEPTH cycles, then → SCAN.
- SCAN:
  - Reads LL 0..LL_DEPTH-1, then D 0..D_DEPTH-1, one address per cycle.
  - For each returned word that is nonzero, records its index as last_ll or last_d.
  - Trackers reset to "none" on entry.
  - Duration LL_DEPTH+D_DEPTH+1 cycles, including the latency drain.
- SCAN → EMIT:
  - n_ll = max(last_ll+1, 257); n_d = max(last_d+1, 1). An all-zero RAM yields the minimum.
  - hlit = n_ll-257; hdist = n_d-1; both registered on the exit cycle.
- EMIT:
  - Streams LL[0..n_ll-1], then D[0..n_d-1]; cl_last=1 only on D[n_d-1].
  - First cl_valid no later than 3 cycles after entering EMIT.
  - A one-entry prefetch/skid register gives sustained 1 element/cycle while cl_ready=1.
  - When cl_valid=1 and cl_ready=0, cl_data and cl_last hold stable and no address advances past the prefetch.
  - cl_valid never deasserts without a transfer.
- DONE: entered on the cycle the cl_last transfer completes. done=1 and busy=0 for one cycle, then → IDLE.
- Throughout: ll_we and d_we are 0 outside CLEAR. Address widths are zero-extended; counters never exceed depth-1.

Optional Feature:
- Macro: CLCODING_SEQUENCER_STATS_EN.
- Defined:
  - Adds output port zero_cnt (9 bits): count of transferred elements with cl_data=0 in the current job.
  - Cleared on start; holds after done.
  - Increments only on a cl_valid&cl_ready transfer with cl_data=0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Cleared RAMs: start with clear_first=1, cl_ready=1 → exactly 286 cycles of ll_we; both RAMs read back 0; hlit=0, hdist=0; 258 elements, all 0; cl_last on the 258th; done pulses once.
- Preloaded RAMs: LL[0..143]=8, LL[144..255]=9, LL[256..279]=7, LL[280..285]=0, D[0..29]=5; start with clear_first=0 → hlit=23, hdist=29; 310 elements in order; cl_last on D[29].
- Trimming: LL[285]=3 only nonzero beyond 256; D[2]=1 only nonzero → hlit=29, hdist=2; stream length 289.
- Backpressure: cl_ready toggles 1,0,0,1 repeatedly → cl_data stable across stalls; no element lost or duplicated; sequence equals the no-stall run.
- Reset and start guard: reset asserted at CLEAR k=100 → ll_we=0 the next cycle; outputs at reset values; a fresh start completes normally. A start pulse during EMIT is ignored.
- STATS_EN: with the preloaded case → zero_cnt=0; with cleared RAMs → zero_cnt=258.
